// File: rtl/uart_bus_regfile_pkg.sv
// Shared constants for the bus-side register file: address map, STATUS bit
// positions and the default ID byte.
package uart_bus_regfile_pkg;

    localparam int unsigned ADDR_ID       = 32'h0000;
    localparam int unsigned ADDR_SCRATCH  = 32'h0001;
    localparam int unsigned ADDR_CTRL     = 32'h0002;
    localparam int unsigned ADDR_STATUS   = 32'h0003;
    localparam int unsigned ADDR_RX_DATA  = 32'h0004;
    localparam int unsigned ADDR_TX_DATA  = 32'h0005;
    localparam int unsigned ADDR_RX_LEVEL = 32'h0006;
    localparam int unsigned ADDR_TX_LEVEL = 32'h0007;
    localparam int unsigned ADDR_TS0      = 32'h0008;
    localparam int unsigned ADDR_TS1      = 32'h0009;
    localparam int unsigned ADDR_TS2      = 32'h000A;
    localparam int unsigned ADDR_TS3      = 32'h000B;

    localparam int unsigned ST_RX_EMPTY = 0;
    localparam int unsigned ST_RX_FULL  = 1;
    localparam int unsigned ST_TX_EMPTY = 2;
    localparam int unsigned ST_TX_FULL  = 3;
    localparam int unsigned ST_RX_OVF   = 4;
    localparam int unsigned ST_TX_OVF   = 5;

    localparam logic [7:0] ID_VALUE_DEFAULT = 8'hA5;

endpackage

// File: rtl/uart_bus_regfile_fifo.sv
// Byte FIFO with show-ahead head output. The caller decides when a push or
// pop is legal; this block simply performs whatever it is told.
module bus_byte_fifo #(
    parameter int FIFO_AW = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               push,
    input  logic               pop,
    input  logic [7:0]         wr_data,
    output logic [7:0]         rd_data,
    output logic [FIFO_AW:0]   level,
    output logic               full,
    output logic               empty
);
    localparam int DEPTH = 1 << FIFO_AW;

    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]   level_q, level_d;

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        level_d  = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    assign empty   = (level_q == '0);
    assign full    = (level_q == (FIFO_AW+1)'(DEPTH));
    // Stale RAM contents are hidden while empty so the head reads as zero.
    assign rd_data = empty ? 8'h00 : mem[rd_ptr_q];
    assign level   = level_q;

endmodule

// File: rtl/uart_bus_regfile.sv
// Byte-wide register file behind the UART bus bridge: ID/scratch/control,
// sticky status, RX/TX mailboxes and an atomically snapshotted timestamp.
module uart_bus_regfile
    import uart_bus_regfile_pkg::*;
#(
    parameter int         AW       = 16,
    parameter int         FIFO_AW  = 4,
    parameter logic [7:0] ID_VALUE = ID_VALUE_DEFAULT
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [AW-1:0] int_address,
    input  logic [7:0]    int_wr_data,
    input  logic          int_write,
    input  logic          int_read,
    output logic [7:0]    int_rd_data,
    output logic [7:0]    ctrl_out,
    input  logic [7:0]    dev_rx_data,
    input  logic          dev_rx_valid,
    output logic [7:0]    dev_tx_data,
    output logic          dev_tx_valid,
    input  logic          dev_tx_ready
);
    logic [7:0]  rd_data_q, rd_data_d;
    logic [7:0]  scratch_q, scratch_d;
    logic [7:0]  ctrl_q, ctrl_d;
    logic        rx_ovf_q, rx_ovf_d;
    logic        tx_ovf_q, tx_ovf_d;
    logic [31:0] ts_q, ts_d;
    logic [31:0] shadow_q, shadow_d;

    logic [7:0]       rx_head, tx_head;
    logic [FIFO_AW:0] rx_level, tx_level;
    logic             rx_full, rx_empty, tx_full, tx_empty;
    logic             rx_push, rx_pop, tx_push, tx_pop;
    logic             tx_wr, status_wr, rx_ovf_set, tx_ovf_set;
    logic [7:0]       status;

    assign rx_pop     = int_read && (int_address == AW'(ADDR_RX_DATA)) && !rx_empty;
    // A host pop on a full RX FIFO frees the slot the device push needs.
    assign rx_push    = dev_rx_valid && (!rx_full || rx_pop);
    assign rx_ovf_set = dev_rx_valid && rx_full && !rx_pop;

    assign tx_wr      = int_write && (int_address == AW'(ADDR_TX_DATA));
    assign tx_pop     = dev_tx_ready && !tx_empty;
    assign tx_push    = tx_wr && (!tx_full || tx_pop);
    assign tx_ovf_set = tx_wr && tx_full && !tx_pop;
    assign status_wr  = int_write && (int_address == AW'(ADDR_STATUS));

    always_comb begin
        status              = 8'h00;
        status[ST_RX_EMPTY] = rx_empty;
        status[ST_RX_FULL]  = rx_full;
        status[ST_TX_EMPTY] = tx_empty;
        status[ST_TX_FULL]  = tx_full;
        status[ST_RX_OVF]   = rx_ovf_q;
        status[ST_TX_OVF]   = tx_ovf_q;
    end

    always_comb begin
        rd_data_d = rd_data_q;
        shadow_d  = shadow_q;
        if (int_read) begin
            case (int_address)
                AW'(ADDR_ID):       rd_data_d = ID_VALUE;
                AW'(ADDR_SCRATCH):  rd_data_d = scratch_q;
                AW'(ADDR_CTRL):     rd_data_d = ctrl_q;
                AW'(ADDR_STATUS):   rd_data_d = status;
                AW'(ADDR_RX_DATA):  rd_data_d = rx_head;
                AW'(ADDR_RX_LEVEL): rd_data_d = 8'(rx_level);
                AW'(ADDR_TX_LEVEL): rd_data_d = 8'(tx_level);
                AW'(ADDR_TS0): begin
                    rd_data_d = ts_q[7:0];
                    shadow_d  = ts_q;
                end
                AW'(ADDR_TS1):      rd_data_d = shadow_q[15:8];
                AW'(ADDR_TS2):      rd_data_d = shadow_q[23:16];
                AW'(ADDR_TS3):      rd_data_d = shadow_q[31:24];
                default:            rd_data_d = 8'h00;
            endcase
        end
    end

    always_comb begin
        scratch_d = scratch_q;
        ctrl_d    = ctrl_q;
        if (int_write && (int_address == AW'(ADDR_SCRATCH))) scratch_d = int_wr_data;
        if (int_write && (int_address == AW'(ADDR_CTRL)))    ctrl_d    = int_wr_data;
        // Set has priority over write-1-to-clear.
        rx_ovf_d = rx_ovf_set || (rx_ovf_q && !(status_wr && int_wr_data[ST_RX_OVF]));
        tx_ovf_d = tx_ovf_set || (tx_ovf_q && !(status_wr && int_wr_data[ST_TX_OVF]));
        ts_d     = ts_q + 32'd1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_data_q <= 8'h00;
            scratch_q <= 8'h00;
            ctrl_q    <= 8'h00;
            rx_ovf_q  <= 1'b0;
            tx_ovf_q  <= 1'b0;
            ts_q      <= 32'd0;
            shadow_q  <= 32'd0;
        end else begin
            rd_data_q <= rd_data_d;
            scratch_q <= scratch_d;
            ctrl_q    <= ctrl_d;
            rx_ovf_q  <= rx_ovf_d;
            tx_ovf_q  <= tx_ovf_d;
            ts_q      <= ts_d;
            shadow_q  <= shadow_d;
        end
    end

    bus_byte_fifo #(.FIFO_AW(FIFO_AW)) u_rx_fifo (
        .clock   (clock),
        .reset   (reset),
        .push    (rx_push),
        .pop     (rx_pop),
        .wr_data (dev_rx_data),
        .rd_data (rx_head),
        .level   (rx_level),
        .full    (rx_full),
        .empty   (rx_empty)
    );

    bus_byte_fifo #(.FIFO_AW(FIFO_AW)) u_tx_fifo (
        .clock   (clock),
        .reset   (reset),
        .push    (tx_push),
        .pop     (tx_pop),
        .wr_data (int_wr_data),
        .rd_data (tx_head),
        .level   (tx_level),
        .full    (tx_full),
        .empty   (tx_empty)
    );

    assign int_rd_data  = rd_data_q;
    assign ctrl_out     = ctrl_q;
    assign dev_tx_data  = tx_head;
    assign dev_tx_valid = !tx_empty;

endmodule

// File: tb/tb_uart_bus_regfile.sv
// Scoreboard bench for uart_bus_regfile: a queue-based reference model
// predicts every read and every TX byte; monitors compare as outputs appear.
module tb_uart_bus_regfile;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] int_address = 16'h0;
    logic [7:0]  int_wr_data = 8'h0;
    logic        int_write = 1'b0;
    logic        int_read = 1'b0;
    logic [7:0]  int_rd_data;
    logic [7:0]  ctrl_out;
    logic [7:0]  dev_rx_data = 8'h0;
    logic        dev_rx_valid = 1'b0;
    logic [7:0]  dev_tx_data;
    logic        dev_tx_valid;
    logic        dev_tx_ready = 1'b0;

    uart_bus_regfile dut (
        .clock        (clock),
        .reset        (reset),
        .int_address  (int_address),
        .int_wr_data  (int_wr_data),
        .int_write    (int_write),
        .int_read     (int_read),
        .int_rd_data  (int_rd_data),
        .ctrl_out     (ctrl_out),
        .dev_rx_data  (dev_rx_data),
        .dev_rx_valid (dev_rx_valid),
        .dev_tx_data  (dev_tx_data),
        .dev_tx_valid (dev_tx_valid),
        .dev_tx_ready (dev_tx_ready)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    // Reference model state
    logic [7:0]  rxq[$];
    logic [7:0]  txq[$];
    logic [7:0]  m_scratch = 8'h00;
    logic [7:0]  m_ctrl = 8'h00;
    logic        m_rx_ovf = 1'b0;
    logic        m_tx_ovf = 1'b0;
    logic [31:0] m_ts = 32'd0;
    logic [31:0] m_shadow = 32'd0;

    // Scoreboard queues
    logic [7:0]  exp_rd_q[$];
    logic [15:0] exp_addr_q[$];
    logic [7:0]  exp_tx_q[$];
    logic        rd_seen = 1'b0;

    function automatic void check8(string name, logic [7:0] act, logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
        end
    endfunction

    // Free-running cycle count, cleared by reset: this is what the timestamp must equal.
    always @(posedge clock or negedge reset) begin
        if (!reset) m_ts <= 32'd0;
        else        m_ts <= m_ts + 32'd1;
    end

    always @(posedge clock or negedge reset) begin
        if (!reset) rd_seen <= 1'b0;
        else        rd_seen <= int_read;
    end

    // Read monitor
    always @(negedge clock) begin
        if (rd_seen) begin
            if (exp_rd_q.size() == 0) begin
                check8("rd_unexpected", int_rd_data, 8'hxx);
            end else begin
                logic [7:0]  e;
                logic [15:0] a;
                e = exp_rd_q.pop_front();
                a = exp_addr_q.pop_front();
                tests++;
                if (int_rd_data !== e) begin
                    fails++;
                    $display("FAIL read addr 0x%04h: got 0x%02h expected 0x%02h", a, int_rd_data, e);
                end else begin
                    $display("[TB] read  addr 0x%04h -> 0x%02h", a, int_rd_data);
                end
            end
        end
    end

    // TX monitor
    always @(negedge clock) begin
        if (reset && dev_tx_valid && dev_tx_ready) begin
            if (exp_tx_q.size() == 0) begin
                check8("tx_unexpected", dev_tx_data, 8'hxx);
            end else begin
                logic [7:0] e;
                e = exp_tx_q.pop_front();
                tests++;
                if (dev_tx_data !== e) begin
                    fails++;
                    $display("FAIL tx_pop: got 0x%02h expected 0x%02h", dev_tx_data, e);
                end else begin
                    $display("[TB] tx    pop -> 0x%02h", dev_tx_data);
                end
            end
        end
    end

    function automatic logic [7:0] model_read(logic [15:0] a);
        case (a)
            16'h0000: return 8'hA5;
            16'h0001: return m_scratch;
            16'h0002: return m_ctrl;
            16'h0003: return {2'b00, m_tx_ovf, m_rx_ovf, txq.size() == 16,
                              txq.size() == 0, rxq.size() == 16, rxq.size() == 0};
            16'h0004: return (rxq.size() > 0) ? rxq[0] : 8'h00;
            16'h0006: return 8'(rxq.size());
            16'h0007: return 8'(txq.size());
            16'h0008: return m_ts[7:0];
            16'h0009: return m_shadow[15:8];
            16'h000A: return m_shadow[23:16];
            16'h000B: return m_shadow[31:24];
            default:  return 8'h00;
        endcase
    endfunction

    // One bus cycle: drive just after a rising edge, predict its effect.
    task automatic step(input logic rd, input logic wr, input logic [15:0] addr,
                        input logic [7:0] wd, input logic rxv, input logic [7:0] rxd,
                        input logic txr);
        logic rx_pop, tx_pop, rx_set, tx_set;
        @(posedge clock);
        #1;
        int_read = rd; int_write = wr; int_address = addr; int_wr_data = wd;
        dev_rx_valid = rxv; dev_rx_data = rxd; dev_tx_ready = txr;
        rx_pop = rd && addr == 16'h0004 && rxq.size() > 0;
        tx_pop = txr && txq.size() > 0;
        rx_set = 1'b0;
        tx_set = 1'b0;
        if (rd) begin
            exp_rd_q.push_back(model_read(addr));
            exp_addr_q.push_back(addr);
            if (addr == 16'h0008) m_shadow = m_ts;
        end
        if (rx_pop) void'(rxq.pop_front());
        if (tx_pop) void'(txq.pop_front());
        if (rxv) begin
            if (rxq.size() < 16) rxq.push_back(rxd);
            else rx_set = 1'b1;
        end
        if (wr) begin
            case (addr)
                16'h0001: m_scratch = wd;
                16'h0002: m_ctrl = wd;
                16'h0003: begin
                    if (wd[4]) m_rx_ovf = 1'b0;
                    if (wd[5]) m_tx_ovf = 1'b0;
                end
                16'h0005: begin
                    if (txq.size() < 16) begin
                        txq.push_back(wd);
                        exp_tx_q.push_back(wd);
                    end else begin
                        tx_set = 1'b1;
                    end
                end
                default: ;
            endcase
        end
        if (rx_set) m_rx_ovf = 1'b1;
        if (tx_set) m_tx_ovf = 1'b1;
    endtask

    task automatic idle(input logic txr);
        step(1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 8'h00, txr);
    endtask
    task automatic rd(input logic [15:0] a);
        step(1'b1, 1'b0, a, 8'h00, 1'b0, 8'h00, 1'b0);
    endtask
    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        step(1'b0, 1'b1, a, d, 1'b0, 8'h00, 1'b0);
    endtask
    task automatic push_rx(input logic [7:0] d);
        step(1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, d, 1'b0);
    endtask

    task automatic clear_model();
        rxq.delete(); txq.delete(); exp_rd_q.delete(); exp_addr_q.delete(); exp_tx_q.delete();
        m_scratch = 8'h00; m_ctrl = 8'h00; m_rx_ovf = 1'b0; m_tx_ovf = 1'b0; m_shadow = 32'd0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        reset = 1'b0;
        #23;
        reset = 1'b1;

        // Reset values
        rd(16'h0000); rd(16'h0001); rd(16'h0003);

        // Scratch / control
        wr(16'h0001, 8'h3C); wr(16'h0002, 8'h81); rd(16'h0001);
        idle(1'b0);
        @(negedge clock);
        check8("ctrl_out", ctrl_out, 8'h81);

        // RX overflow and drain
        for (int i = 0; i < 17; i++) push_rx(8'(i));
        rd(16'h0006); rd(16'h0003);
        for (int i = 0; i < 17; i++) rd(16'h0004);
        rd(16'h0003);
        wr(16'h0003, 8'h10); rd(16'h0003);

        // TX show-ahead and device pops
        wr(16'h0005, 8'h11); wr(16'h0005, 8'h22);
        idle(1'b0);
        @(negedge clock);
        check8("tx_valid_after_push", {7'd0, dev_tx_valid}, 8'h01);
        check8("tx_head_after_push", dev_tx_data, 8'h11);
        idle(1'b1); idle(1'b1); idle(1'b0);
        @(negedge clock);
        check8("tx_valid_drained", {7'd0, dev_tx_valid}, 8'h00);
        for (int i = 0; i < 17; i++) wr(16'h0005, 8'(8'h40 + i));
        rd(16'h0003); rd(16'h0007);
        for (int i = 0; i < 16; i++) idle(1'b1);
        wr(16'h0003, 8'h20); rd(16'h0003);

        // Full RX with simultaneous push and host pop
        for (int i = 0; i < 16; i++) push_rx(8'(8'h80 + i));
        step(1'b1, 1'b0, 16'h0004, 8'h00, 1'b1, 8'hEE, 1'b0);
        rd(16'h0006); rd(16'h0003);
        for (int i = 0; i < 16; i++) rd(16'h0004);
        // Empty RX: push and read together
        step(1'b1, 1'b0, 16'h0004, 8'h00, 1'b1, 8'h5A, 1'b0);
        rd(16'h0006); rd(16'h0004);

        // Timestamp snapshot around 0x1FF
        guard = 0;
        while (m_ts < 32'h1FE && guard < 2000) begin idle(1'b0); guard++; end
        rd(16'h0008);
        idle(1'b0); idle(1'b0);
        rd(16'h0009); rd(16'h000A); rd(16'h000B);
        wr(16'h0008, 8'hFF); rd(16'h0009);
        rd(16'h0100); rd(16'hFFFF); wr(16'h0100, 8'h77); rd(16'h0001);

        // Randomized traffic
        for (int i = 0; i < 2500; i++) begin
            logic [15:0] a;
            int sel;
            sel = int'($urandom_range(0, 15));
            a = (sel < 12) ? 16'(sel) : (sel == 12) ? 16'h000C : (sel == 13) ? 16'h0100 : 16'hFFFF;
            step($urandom_range(0, 1) == 1, $urandom_range(0, 9) < 3, a, 8'($urandom),
                 $urandom_range(0, 9) < 4, 8'($urandom), $urandom_range(0, 9) < 3);
        end
        for (int i = 0; i < 20; i++) idle(1'b1);

        // Mid-sequence asynchronous reset
        wr(16'h0002, 8'hC3); wr(16'h0005, 8'h99); push_rx(8'h12); rd(16'h0002); idle(1'b0);
        @(posedge clock);
        #2;
        reset = 1'b0;
        clear_model();
        #1;
        check8("rst_rd_data", int_rd_data, 8'h00);
        check8("rst_ctrl_out", ctrl_out, 8'h00);
        check8("rst_tx_valid", {7'd0, dev_tx_valid}, 8'h00);
        check8("rst_tx_data", dev_tx_data, 8'h00);
        @(negedge clock);
        reset = 1'b1;
        rd(16'h0003); rd(16'h0006); rd(16'h0004); rd(16'h0002);
        idle(1'b0); idle(1'b0);
        @(negedge clock);
        check8("rd_queue_empty", 8'(exp_rd_q.size()), 8'h00);
        check8("tx_queue_empty", 8'(exp_tx_q.size()), 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
